renode_ahb_subordinate_memory: RTL and testbench
================================================

# renode_ahb_subordinate_memory

Synthesizable AHB-Lite subordinate backed by a word-addressed memory array. It is the responder end of the bus driven by the Renode AHB manager, and it gives co-simulation benches a known-good target with configurable wait states and protocol-correct ERROR responses. It sits behind an AHB decoder/mux (`hsel`, `hready`) or attaches directly to a single manager, with `hready` tied to `hreadyout`.

## Interface
- `AddressWidth`, 32, width of `haddr`.
- `DataWidth`, 32, width of `hwdata`/`hrdata`; must be 32 or 64.
- `MemoryDepth`, 1024, number of `DataWidth`-bit words.
- `BaseAddress`, 0, byte address of word 0; must be aligned to `DataWidth/8`.
- `WaitStates`, 0, number of `hreadyout`-low cycles inserted into every OKAY data phase (0..15).

Ports:
- `hclk`  in  1  bus clock; all state changes on its rising edge.
- `hreset`  in  1  asynchronous, active-high reset.
- `hsel`  in  1  subordinate select.
- `haddr`  in  AddressWidth  byte address.
- `htrans`  in  2  Idle=0, Busy=1, NonSequential=2, Sequential=3.
- `hwrite`  in  1  1 = write.
- `hsize`  in  3  transfer size, log2 of bytes.
- `hburst`  in  3  ignored; each beat carries its own address.
- `hwstrb`  in  DataWidth/8  write byte strobes, sampled with `hwdata`.
- `hwdata`  in  DataWidth  write data.
- `hready`  in  1  bus-level ready; an address phase is sampled only when this is high.
- `hreadyout`  out  1  this subordinate's ready.
- `hresp`  out  1  0 = OKAY, 1 = ERROR.
- `hrdata`  out  DataWidth  read data.

## Operation
- Transfer acceptance: a transfer is accepted on a rising edge with `hsel && hready && htrans[1]`.
  - On acceptance, latch `haddr`, `hwrite`, `hsize`.
  - Idle or Busy, or `hsel` low, gives a zero-wait OKAY with no side effect.
- Error check, performed at acceptance. A transfer is an error if any of the following holds:
  - `haddr` lies outside [BaseAddress, BaseAddress + MemoryDepth*DataWidth/8).
  - `hsize` > log2(DataWidth/8).
  - `haddr` is not aligned to 2^`hsize`.
- State machine, with states IDLE, WAIT, DATA, ERR1, ERR2:
  - IDLE: `hreadyout`=1, `hresp`=0. Accepted OK transfer goes to WAIT if `WaitStates`>0, else to DATA. Accepted error goes to ERR1.
  - WAIT: `hreadyout`=0, `hresp`=0. A counter loaded with `WaitStates`-1 decrements each cycle; at 0 the state goes to DATA.
  - DATA: `hreadyout`=1, `hresp`=0; this is the final data-phase cycle.
    - Write: commit at the closing edge. Byte enable = size/offset lane mask AND `hwstrb`.
    - Read: `hrdata` = mem[latched word] in this cycle.
    - A new transfer accepted in this cycle is handled as from IDLE (pipelined back-to-back). Otherwise the state goes to IDLE.
  - ERR1: `hreadyout`=0, `hresp`=1. Always goes to ERR2.
  - ERR2: `hreadyout`=1, `hresp`=1. No memory access. A new transfer may be accepted here, as from IDLE.
- Error handling: erroring writes never modify memory.
- `hrdata`: 0 in every cycle except DATA of a read.
- Lane mapping: lane = `haddr[log2(DataWidth/8)-1:0]`. Sub-word reads return the full word; the manager selects lanes.
- Read-after-write: a read accepted in the same edge that commits a write to the same word returns the newly written bytes.
- Memory contents are not reset.

## Timing
- Reset, asynchronous, takes effect immediately:
  - state = IDLE, `hreadyout`=1, `hresp`=0, `hrdata`=0, wait counter = 0.
  - Any in-flight write is discarded.
  - Deassertion is synchronized to `hclk`; the first acceptance is possible on the first rising edge after deassertion.
- OKAY latency: address-phase edge to the final data-phase cycle is 1 + `WaitStates` cycles.
- ERROR: exactly two data-phase cycles (ERR1, ERR2), independent of `WaitStates`.
- Stall behaviour: while `hready` is low, `htrans`/`haddr` changes are ignored; no acceptance occurs.
- Sustained throughput: with `WaitStates`=0, one transfer per cycle.

## Test plan
- Reset and idle:
  - Assert `hreset` mid-WAIT with a write pending.
  - Required: outputs go to 1/0/0 immediately. A later read of that address returns the prior contents.
- Back-to-back write/read, `WaitStates`=0:
  - Write 32'hDEADBEEF to 0x10, followed immediately by a read of 0x10.
  - Required: `hreadyout` never drops; read returns 32'hDEADBEEF one cycle after its address phase.
- Byte write:
  - Byte write, `hsize`=0 at 0x13, `hwdata`=32'hAA000000, `hwstrb`=4'hF, over a word holding 32'h11223344.
  - Required: read returns 32'hAA223344.
- Wait states, `WaitStates`=3:
  - Read 0x0.
  - Required: `hreadyout` low for exactly 3 cycles, then high with valid `hrdata`.
- Error responses:
  - Cases: out-of-range address 0x1000 (depth 1024), `hsize`=2 at 0x2, and `hsize`=3 on a 32-bit bus.
  - Required for each: `hreadyout`=0/`hresp`=1, then `hreadyout`=1/`hresp`=1; memory unchanged.
  - Required: a transfer issued during ERR2 completes OKAY.
- Idle/Busy traffic:
  - Idle and Busy with `hsel`=1, plus NonSequential with `hsel`=0.
  - Required: zero-wait OKAY, no memory change, `hrdata`=0.

Source files
------------

// File: rtl/renode_ahb_subordinate_memory.sv
// ---------------------------------------------------------------------------
// renode_ahb_subordinate_memory
//
// AHB-Lite subordinate backed by a word-addressed memory array. It provides a
// known-good target for co-simulation with configurable wait states and
// two-cycle ERROR responses.
//
// Handshake: an address phase is taken on a rising edge when
// hsel && hready && htrans[1]. The data phase then runs until the edge on
// which hreadyout is high; that edge closes it (write commit, read data
// consumed) and may take the next address phase in the same cycle.
//
// Ports:
//   hclk, hreset          clock, asynchronous active-high reset
//   hsel, hready          select and bus-level ready (address qualifier)
//   haddr, htrans,
//   hwrite, hsize, hburst address-phase controls (hburst ignored)
//   hwstrb, hwdata        data-phase write strobes and data
//   hreadyout, hresp      subordinate ready and OKAY(0)/ERROR(1) response
//   hrdata                read data, zero outside the final read data cycle
//   o_dbg_state           current FSM state (IDLE=0 WAIT=1 DATA=2 ERR1=3 ERR2=4)
// ---------------------------------------------------------------------------
module renode_ahb_subordinate_memory #(
    parameter int                    AddressWidth = 32,
    parameter int                    DataWidth    = 32,
    parameter int                    MemoryDepth  = 1024,
    parameter logic [AddressWidth-1:0] BaseAddress = '0,
    parameter int                    WaitStates   = 0
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    hsel,
    input  logic [AddressWidth-1:0] haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [DataWidth/8-1:0]  hwstrb,
    input  logic [DataWidth-1:0]    hwdata,
    input  logic                    hready,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [DataWidth-1:0]    hrdata,
    output logic [2:0]              o_dbg_state
);

    localparam int STRB      = DataWidth / 8;
    localparam int LANE_BITS = $clog2(STRB);
    localparam int IDX_W     = $clog2(MemoryDepth);
    localparam logic [63:0] MEM_BYTES = 64'(MemoryDepth) * 64'(STRB);
    localparam logic [3:0]  WAIT_LOAD = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_wait_cnt;
    logic [3:0]             w_wait_next;
    logic [IDX_W-1:0]       r_word;
    logic [LANE_BITS-1:0]   r_lane;
    logic [2:0]             r_size;
    logic                   r_write;
    logic [DataWidth-1:0]   r_mem [MemoryDepth];

    logic [AddressWidth-1:0] w_offset;
    logic [AddressWidth-1:0] w_word_full;
    logic [7:0]              w_size_mask;
    logic                    w_err;
    logic                    w_can_accept;
    logic                    w_accept;
    logic [STRB-1:0]         w_lane_mask;
    logic [STRB-1:0]         w_be;
    logic                    w_unused;

    // Address decode and protocol checks on the live address phase.
    assign w_offset    = haddr - BaseAddress;
    assign w_word_full = w_offset >> LANE_BITS;
    // Low address bits that must be zero for a naturally aligned transfer.
    assign w_size_mask = (8'd1 << hsize) - 8'd1;
    assign w_err = (haddr < BaseAddress)
                || (64'(w_offset) >= MEM_BYTES)
                || (hsize > 3'(LANE_BITS))
                || (|(haddr[7:0] & w_size_mask));

    // Only cycles whose hreadyout is high can close a data phase, so only
    // those can overlap the next address phase.
    assign w_can_accept = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
    assign w_accept     = hsel && hready && htrans[1] && w_can_accept;

    assign o_dbg_state  = r_state;
    assign w_unused     = &{1'b0, hburst, htrans[0], w_word_full};

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_wait_next = r_wait_cnt;
        hreadyout   = 1'b1;
        hresp       = 1'b0;
        case (r_state)
            S_IDLE, S_DATA, S_ERR2: begin
                hresp  = (r_state == S_ERR2);
                w_next = S_IDLE;
                if (w_accept) begin
                    if (w_err) begin
                        w_next = S_ERR1;
                    end else if (WaitStates > 0) begin
                        w_next      = S_WAIT;
                        w_wait_next = WAIT_LOAD;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_WAIT: begin
                hreadyout = 1'b0;
                if (r_wait_cnt == 4'd0) begin
                    w_next = S_DATA;
                end else begin
                    w_wait_next = r_wait_cnt - 4'd1;
                end
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                w_next    = S_ERR2;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Address-phase latches for the transfer now in its data phase.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_word  <= '0;
            r_lane  <= '0;
            r_size  <= 3'd0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_word  <= w_word_full[IDX_W-1:0];
            r_lane  <= haddr[LANE_BITS-1:0];
            r_size  <= hsize;
            r_write <= hwrite;
        end
    end

    // Bytes covered by the latched size/offset; errors never reach DATA, so
    // r_size is always within the bus width here.
    always_comb begin
        w_lane_mask = '0;
        for (int b = 0; b < STRB; b++) begin
            w_lane_mask[b] = (b >= int'(r_lane)) && (b < int'(r_lane) + (1 << r_size));
        end
    end

    assign w_be = w_lane_mask & hwstrb;

    // Memory is not reset; reset forces IDLE so a pending write never commits.
    always_ff @(posedge hclk) begin
        if (r_state == S_DATA && r_write) begin
            for (int b = 0; b < STRB; b++) begin
                if (w_be[b]) begin
                    r_mem[r_word][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        hrdata = '0;
        if (r_state == S_DATA && !r_write) begin
            hrdata = r_mem[r_word];
        end
    end

endmodule

// File: tb/tb_renode_ahb_subordinate_memory.sv
// ---------------------------------------------------------------------------
// Bench for renode_ahb_subordinate_memory. Two instances share one AHB bus
// through a small decoder/mux: dut0 with WaitStates=0, dut1 with
// WaitStates=3. A driver issues directed beats and queues the expected
// response; a monitor closes data phases and compares.
// Expected entry: {resp[36], wait_cycles[35:32], rdata[31:0]}.
// ---------------------------------------------------------------------------
module tb_renode_ahb_subordinate_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hsel0, hsel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hwstrb;
    logic [31:0] hwdata;
    logic        hready;
    logic        ro0, ro1, resp0, resp1;
    logic [31:0] rd0, rd1;
    logic [2:0]  st0, st1;
    logic        dsel, dp_active;
    logic        hresp_m;
    logic [31:0] hrdata_m;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          wait_cnt = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_e;
    logic [31:0] pend_wdata;
    logic [3:0]  pend_wstrb;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    renode_ahb_subordinate_memory #(.WaitStates(0)) dut0 (
        .hclk(clk), .hreset(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwstrb(hwstrb),
        .hwdata(hwdata), .hready(hready), .hreadyout(ro0), .hresp(resp0),
        .hrdata(rd0), .o_dbg_state(st0)
    );

    renode_ahb_subordinate_memory #(.WaitStates(3)) dut1 (
        .hclk(clk), .hreset(rst), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwstrb(hwstrb),
        .hwdata(hwdata), .hready(hready), .hreadyout(ro1), .hresp(resp1),
        .hrdata(rd1), .o_dbg_state(st1)
    );

    // Data-phase mux: the subordinate addressed last owns hready/hresp/hrdata.
    assign hready   = dsel ? ro1 : ro0;
    assign hresp_m  = dsel ? resp1 : resp0;
    assign hrdata_m = dsel ? rd1 : rd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dsel      <= 1'b0;
            dp_active <= 1'b0;
        end else if (hready) begin
            dsel      <= hsel1;
            dp_active <= (hsel0 || hsel1) && htrans[1];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            wait_cnt = 0;
        end else if (dp_active) begin
            if (exp_q.size() == 0) begin
                check("queue_occupancy", 32'(exp_q.size()), 32'd1);
            end else if (!hready) begin
                mon_e = exp_q[0];
                check("wait_hresp", {31'd0, hresp_m}, {31'd0, mon_e[36]});
                check("wait_hrdata", hrdata_m, 32'd0);
                wait_cnt++;
                if (wait_cnt > 20) begin
                    check("wait_budget", 32'(wait_cnt), {28'd0, mon_e[35:32]});
                    mon_e    = exp_q.pop_front();
                    wait_cnt = 0;
                end
            end else begin
                mon_e = exp_q.pop_front();
                check("resp", {31'd0, hresp_m}, {31'd0, mon_e[36]});
                check("wait_cycles", 32'(wait_cnt), {28'd0, mon_e[35:32]});
                check("rdata", hrdata_m, mon_e[31:0]);
                wait_cnt = 0;
            end
        end else begin
            check("idle_hready", {31'd0, hready}, 32'd1);
            check("idle_hresp", {31'd0, hresp_m}, 32'd0);
            check("idle_hrdata", hrdata_m, 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    // tgt: 0 = dut0, 1 = dut1, 2 = nobody selected. Called at posedge+1.
    task automatic beat(input int tgt, input logic [1:0] tr, input logic wr,
                        input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic eresp, input logic [31:0] erd);
        logic [3:0] w;
        hsel0  = (tgt == 0);
        hsel1  = (tgt == 1);
        htrans = tr;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        hwdata = pend_wdata;
        hwstrb = pend_wstrb;
        if (tgt < 2 && tr[1]) begin
            w = eresp ? 4'd1 : ((tgt == 1) ? 4'd3 : 4'd0);
            exp_q.push_back({eresp, w, (eresp || wr) ? 32'd0 : erd});
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (hready) break;
        end
        if (!hready) check("hready_budget", {31'd0, hready}, 32'd1);
        @(posedge clk);
        #1;
        if (tgt < 2 && tr[1] && wr) begin
            pend_wdata = wd;
            pend_wstrb = ws;
        end else begin
            pend_wdata = 32'hBAD0BAD0;
            pend_wstrb = 4'hF;
        end
    endtask

    task automatic wr_t(input int tgt, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] d, input logic [3:0] ws);
        beat(tgt, 2'd2, 1'b1, a, sz, d, ws, 1'b0, 32'd0);
    endtask

    task automatic rd_t(input int tgt, input logic [31:0] a, input logic [31:0] e);
        beat(tgt, 2'd2, 1'b0, a, 3'd2, 32'd0, 4'h0, 1'b0, e);
    endtask

    task automatic err_t(input int tgt, input logic wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] d);
        beat(tgt, 2'd2, wr, a, sz, d, 4'hF, 1'b1, 32'd0);
    endtask

    task automatic idle_t();
        beat(2, 2'd0, 1'b0, 32'd0, 3'd0, 32'd0, 4'h0, 1'b0, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        hsel0 = 0; hsel1 = 0; haddr = 0; htrans = 0; hwrite = 0;
        hsize = 0; hburst = 0; hwstrb = 0; hwdata = 0;
        pend_wdata = 0; pend_wstrb = 0;
        #2 rst = 1'b1;
        #1;
        check("rst_hreadyout0", {31'd0, ro0}, 32'd1);
        check("rst_hresp0", {31'd0, resp0}, 32'd0);
        check("rst_hrdata0", rd0, 32'd0);
        check("rst_hreadyout1", {31'd0, ro1}, 32'd1);
        check("rst_hresp1", {31'd0, resp1}, 32'd0);
        check("rst_hrdata1", rd1, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back write then read, zero wait states.
        wr_t(0, 32'h10, 3'd2, 32'hDEADBEEF, 4'hF);
        rd_t(0, 32'h10, 32'hDEADBEEF);

        // Sub-word writes and strobes.
        wr_t(0, 32'h10, 3'd2, 32'h11223344, 4'hF);
        wr_t(0, 32'h13, 3'd0, 32'hAA000000, 4'hF);
        rd_t(0, 32'h10, 32'hAA223344);
        wr_t(0, 32'h14, 3'd2, 32'h00000000, 4'hF);
        wr_t(0, 32'h16, 3'd1, 32'hBEEF0000, 4'hF);
        rd_t(0, 32'h14, 32'hBEEF0000);
        wr_t(0, 32'h18, 3'd2, 32'hFFFFFFFF, 4'hF);
        wr_t(0, 32'h18, 3'd2, 32'h00000000, 4'h5);
        rd_t(0, 32'h18, 32'hFF00FF00);

        // Errors; each following read is issued during ERR2.
        wr_t(0, 32'h0, 3'd2, 32'h01020304, 4'hF);
        err_t(0, 1'b1, 32'h1000, 3'd2, 32'h55555555);
        rd_t(0, 32'h0, 32'h01020304);
        err_t(0, 1'b1, 32'h2, 3'd2, 32'h66666666);
        rd_t(0, 32'h0, 32'h01020304);
        err_t(0, 1'b1, 32'h10, 3'd3, 32'h77777777);
        rd_t(0, 32'h10, 32'hAA223344);
        err_t(0, 1'b0, 32'h1, 3'd1, 32'd0);
        rd_t(0, 32'h14, 32'hBEEF0000);

        // Idle/Busy selected, and NonSequential unselected.
        beat(0, 2'd0, 1'b1, 32'h0, 3'd2, 32'hFFFFFFFF, 4'hF, 1'b0, 32'd0);
        beat(0, 2'd1, 1'b1, 32'h0, 3'd2, 32'hFFFFFFFF, 4'hF, 1'b0, 32'd0);
        beat(2, 2'd2, 1'b1, 32'h0, 3'd2, 32'hFFFFFFFF, 4'hF, 1'b0, 32'd0);
        idle_t();
        rd_t(0, 32'h0, 32'h01020304);

        // Three wait states on dut1; error stays two cycles.
        wr_t(1, 32'h0, 3'd2, 32'h0000A5A5, 4'hF);
        rd_t(1, 32'h0, 32'h0000A5A5);
        err_t(1, 1'b0, 32'h1000, 3'd2, 32'd0);
        rd_t(1, 32'h0, 32'h0000A5A5);

        // Reset while a write sits in WAIT: it must be dropped.
        wr_t(1, 32'h20, 3'd2, 32'hCAFEF00D, 4'hF);
        wr_t(1, 32'h20, 3'd2, 32'h0BADBEEF, 4'hF);
        hsel1  = 1'b0;
        htrans = 2'd0;
        hwdata = pend_wdata;
        hwstrb = pend_wstrb;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midwait_rst_hreadyout", {31'd0, ro1}, 32'd1);
        check("midwait_rst_hresp", {31'd0, resp1}, 32'd0);
        check("midwait_rst_hrdata", rd1, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        pend_wdata = 32'hBAD0BAD0;
        pend_wstrb = 4'hF;
        rd_t(1, 32'h20, 32'hCAFEF00D);

        repeat (3) idle_t();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
